// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg: shared types and encodings for the multi-cycle control unit.
//   state_t       - FSM state encoding (also the state_dbg output value)
//   instr_type_t  - decoded instruction type; codes 6 and 7 are illegal
//   WB_SEL_*      - write-back source select values
//   CAUSE_*       - trap cause codes
// ---------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_REG_READ  = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        IT_R      = 3'd0,
        IT_I      = 3'd1,
        IT_LOAD   = 3'd2,
        IT_STORE  = 3'd3,
        IT_BRANCH = 3'd4,
        IT_JAL    = 3'd5
    } instr_type_t;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic logic type_is_legal(input logic [2:0] t);
        return (t <= 3'd5);
    endfunction

    // Types whose second ALU operand is the immediate.
    function automatic logic type_uses_imm(input instr_type_t t);
        return (t == IT_I) || (t == IT_LOAD) || (t == IT_STORE) || (t == IT_JAL);
    endfunction

endpackage

// File: rtl/cu_watchdog.sv
// ---------------------------------------------------------------------------
// cu_watchdog: counts cycles spent waiting in a handshake state.
//   clk, reset    - clock, asynchronous active-high reset
//   state_change  - high when the FSM moves to a new state on the next edge
//   waiting       - high while the FSM sits in a handshake state
//   ack           - the ack belonging to the current handshake state
//   expired       - high in the TIMEOUT_CYC-th waiting cycle when no ack came
// Only instantiated when CU_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module cu_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic state_change,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Cleared on the edge that enters a new state, so the first cycle of
    // every state sees a count of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_change) begin
            cnt <= '0;
        end else if (waiting && (cnt != CW'(TIMEOUT_CYC))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = waiting && !ack && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, REG_READ, EXECUTE, MEM and WRITEBACK
// using one req/ack handshake per stage, updates pc on retire, and parks in
// TRAP on an illegal type (or on a handshake timeout when built with
// CU_TIMEOUT_EN defined).
//
// Handshake rule: a stage's req is high for the whole time the FSM is in that
// state; a transfer happens on the rising edge where req and ack are both
// high, and the next state is entered on that same edge. Acks seen while the
// matching req is low have no effect.
//
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   run                    - permits fetching new instructions
//   pc                     - address of the current instruction
//   instr_req/ack          - fetch+decode; instr_type and imm valid with ack
//   rf_req/ack             - register read
//   alu_req/ack, alu_isimm - execute; alu_taken valid with alu_ack
//   mem_req/we/ack         - memory access (we=1 for store)
//   wb_req/sel/ack         - write-back (sel 0=ALU, 1=MEM, 2=PC+4)
//   retire                 - high in the cycle whose edge completes an instr
//   busy                   - high outside IDLE and TRAP
//   trap, trap_cause       - sticky fault flag and cause (1=illegal, 2=timeout)
//   state_dbg              - current FSM state
// Optional feature macro: CU_TIMEOUT_EN (handshake watchdog).
// ---------------------------------------------------------------------------
module mc_control_unit
    import cu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [XLEN-1:0] pc,
    output logic            instr_req,
    input  logic            instr_ack,
    input  logic [2:0]      instr_type,
    input  logic [XLEN-1:0] imm,
    output logic            rf_req,
    input  logic            rf_ack,
    output logic            alu_req,
    input  logic            alu_ack,
    output logic            alu_isimm,
    input  logic            alu_taken,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            wb_req,
    output logic [1:0]      wb_sel,
    input  logic            wb_ack,
    output logic            retire,
    output logic            busy,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [2:0]      state_dbg
);

    state_t          state_q, state_d;
    instr_type_t     type_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic            trap_q;
    logic [1:0]      cause_q;
    logic            trap_armed_q;   // run has been seen low while in TRAP

    logic            retire_c;
    logic            trap_set;
    logic [1:0]      cause_set;
    logic            recover;
    logic            take_target;
    logic [XLEN-1:0] pc_next;

`ifdef CU_TIMEOUT_EN
    logic cur_ack;
    logic wd_waiting;
    logic wd_expired;

    always_comb begin
        cur_ack = 1'b0;
        case (state_q)
            ST_FETCH:     cur_ack = instr_ack;
            ST_REG_READ:  cur_ack = rf_ack;
            ST_EXECUTE:   cur_ack = alu_ack;
            ST_MEM:       cur_ack = mem_ack;
            ST_WRITEBACK: cur_ack = wb_ack;
            default:      cur_ack = 1'b0;
        endcase
    end

    assign wd_waiting = (state_q != ST_IDLE) && (state_q != ST_TRAP);

    cu_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .state_change (state_d != state_q),
        .waiting      (wd_waiting),
        .ack          (cur_ack),
        .expired      (wd_expired)
    );
`endif

    // Branch alu_taken is only meaningful on the EXECUTE retire edge, which is
    // the only place a branch ever retires.
    assign take_target = (type_q == IT_JAL) || ((type_q == IT_BRANCH) && alu_taken);
    assign pc_next     = take_target ? (pc_q + imm_q) : (pc_q + XLEN'(4));

    always_comb begin
        state_d   = state_q;
        retire_c  = 1'b0;
        trap_set  = 1'b0;
        cause_set = CAUSE_NONE;
        recover   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_ack) begin
                    if (type_is_legal(instr_type)) begin
                        state_d = ST_REG_READ;
                    end else begin
                        state_d   = ST_TRAP;
                        trap_set  = 1'b1;
                        cause_set = CAUSE_ILLEGAL;
                    end
                end
            end
            ST_REG_READ: begin
                if (rf_ack) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (alu_ack) begin
                    case (type_q)
                        IT_LOAD, IT_STORE: state_d  = ST_MEM;
                        IT_BRANCH:         retire_c = 1'b1;
                        default:           state_d  = ST_WRITEBACK;
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (type_q == IT_LOAD) state_d = ST_WRITEBACK;
                    else                   retire_c = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (wb_ack) retire_c = 1'b1;
            end
            ST_TRAP: begin
                if (run && trap_armed_q) begin
                    state_d = ST_IDLE;
                    recover = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire_c) state_d = run ? ST_FETCH : ST_IDLE;

`ifdef CU_TIMEOUT_EN
        // Expiry implies no ack this cycle, so it never collides with retire.
        if (wd_expired) begin
            state_d   = ST_TRAP;
            trap_set  = 1'b1;
            cause_set = CAUSE_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            type_q       <= IT_R;
            imm_q        <= '0;
            pc_q         <= RESET_PC;
            trap_q       <= 1'b0;
            cause_q      <= CAUSE_NONE;
            trap_armed_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == ST_FETCH) && instr_ack && type_is_legal(instr_type)) begin
                type_q <= instr_type_t'(instr_type);
                imm_q  <= imm;
            end

            if (retire_c)     pc_q <= pc_next;
            else if (recover) pc_q <= RESET_PC;

            if (trap_set) begin
                trap_q       <= 1'b1;
                cause_q      <= cause_set;
                trap_armed_q <= 1'b0;
            end else if (recover) begin
                trap_q       <= 1'b0;
                cause_q      <= CAUSE_NONE;
                trap_armed_q <= 1'b0;
            end else if ((state_q == ST_TRAP) && !run) begin
                trap_armed_q <= 1'b1;
            end
        end
    end

    assign pc         = pc_q;
    assign instr_req  = (state_q == ST_FETCH);
    assign rf_req     = (state_q == ST_REG_READ);
    assign alu_req    = (state_q == ST_EXECUTE);
    assign alu_isimm  = (state_q == ST_EXECUTE) && type_uses_imm(type_q);
    assign mem_req    = (state_q == ST_MEM);
    assign mem_we     = (state_q == ST_MEM) && (type_q == IT_STORE);
    assign wb_req     = (state_q == ST_WRITEBACK);
    assign wb_sel     = (state_q != ST_WRITEBACK) ? WB_SEL_ALU :
                        (type_q == IT_LOAD)       ? WB_SEL_MEM :
                        (type_q == IT_JAL)        ? WB_SEL_PC4 : WB_SEL_ALU;
    assign retire     = retire_c;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
  import cu_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] pc, imm;
  logic        instr_req, instr_ack, rf_req, rf_ack, alu_req, alu_ack, alu_isimm, alu_taken;
  logic        mem_req, mem_we, mem_ack, wb_req, wb_ack, retire, busy, trap;
  logic [2:0]  instr_type, state_dbg;
  logic [1:0]  wb_sel, trap_cause;

  always #5 clk = ~clk;

  mc_control_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc),
    .instr_req(instr_req), .instr_ack(instr_ack), .instr_type(instr_type), .imm(imm),
    .rf_req(rf_req), .rf_ack(rf_ack),
    .alu_req(alu_req), .alu_ack(alu_ack), .alu_isimm(alu_isimm), .alu_taken(alu_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .wb_req(wb_req), .wb_sel(wb_sel), .wb_ack(wb_ack),
    .retire(retire), .busy(busy), .trap(trap), .trap_cause(trap_cause),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (type codes: R0 I1 LD2 ST3 BR4 JAL5) ----------------
  function automatic int model_latency(input logic [2:0] t, input int df, dr, da, dm, dw);
    int l;
    l = (df + 1) + (dr + 1) + (da + 1);
    if (t == 3'd2)       l += (dm + 1) + (dw + 1);
    else if (t == 3'd3)  l += dm + 1;
    else if (t != 3'd4)  l += dw + 1;
    return l;
  endfunction

  function automatic logic [31:0] model_next_pc(input logic [31:0] p, input logic [2:0] t,
                                                input logic [31:0] im, input bit tk);
    if (t == 3'd5 || (t == 3'd4 && tk)) return p + im;
    return p + 32'd4;
  endfunction

  function automatic logic [1:0] model_wb_sel(input logic [2:0] t);
    if (t == 3'd2) return 2'd1;
    if (t == 3'd5) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit model_has_wb(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd5);
  endfunction

  function automatic bit model_isimm(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd2) || (t == 3'd3) || (t == 3'd5);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_acks();
    instr_ack = 1'b0; rf_ack = 1'b0; alu_ack = 1'b0; mem_ack = 1'b0; wb_ack = 1'b0;
  endtask

  // Runs one instruction from IDLE(run=1)/FETCH to retire. Each stage's ack is
  // raised after the given number of wait cycles; with noise set, the acks of
  // inactive stages toggle randomly.
  task automatic do_instr(input logic [2:0] t, input logic [31:0] im, input bit tk,
                          input int df, dr, da, dm, dw, input bit noise, input bit drop_run,
                          output int lat, output int mem_cyc);
    int s, prev, stage_cyc, iter;
    bit done, wb_seen, bad_isimm, bad_we, bad_sel;
    lat = 0; mem_cyc = 0; prev = -1; stage_cyc = 0; iter = 0;
    done = 0; wb_seen = 0; bad_isimm = 0; bad_we = 0; bad_sel = 0;
    while (!done && iter < 300) begin
      @(negedge clk);
      iter++;
      s = instr_req ? 0 : rf_req ? 1 : alu_req ? 2 : mem_req ? 3 : wb_req ? 4 : -1;
      stage_cyc = (s == prev) ? stage_cyc + 1 : 0;
      prev = s;
      instr_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rf_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      instr_type = t; imm = im; alu_taken = tk;
      case (s)
        0: begin lat++; instr_ack = (stage_cyc == df); end
        1: begin lat++; rf_ack    = (stage_cyc == dr); end
        2: begin lat++; alu_ack   = (stage_cyc == da); if (drop_run) run = 1'b0; end
        3: begin lat++; mem_ack   = (stage_cyc == dm); end
        4: begin lat++; wb_ack    = (stage_cyc == dw); end
        default: ;
      endcase
      #1;
      if (s == 2 && alu_isimm !== model_isimm(t)) bad_isimm = 1;
      if (s == 3) begin
        mem_cyc++;
        if (mem_we !== (t == 3'd3)) bad_we = 1;
      end
      if (s == 4) begin
        wb_seen = 1;
        if (wb_sel !== model_wb_sel(t)) bad_sel = 1;
      end
      if (retire === 1'b1) done = 1;
    end
    check("retire_seen", 32'(done), 32'd1);
    check("alu_isimm", 32'(bad_isimm), 32'd0);
    check("mem_we", 32'(bad_we), 32'd0);
    check("wb_sel", 32'(bad_sel), 32'd0);
    check("wb_req_used", 32'(wb_seen), 32'(model_has_wb(t)));
    @(posedge clk);
    #1;
    clear_acks();
    check("retire_pulse_low", 32'(retire), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  t;
    logic [31:0] im;
    bit          tk;
    int          df, dr, da, dm, dw;
    int          exp_lat;
    logic [31:0] exp_pc;
    int          exp_mem;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, mcyc;
    logic [2:0]  t;
    logic [31:0] im, exp_pc;
    bit          tk;
    int          df, dr, da, dm, dw, exp_lat;

    vecs[0] = '{3'd0, 32'h0,        1'b0, 0, 0, 0, 0, 0,  4, 32'h4,        0};
    vecs[1] = '{3'd1, 32'h55,       1'b0, 1, 0, 2, 0, 0,  7, 32'h8,        0};
    vecs[2] = '{3'd5, 32'hF8,       1'b0, 0, 0, 0, 0, 0,  4, 32'h100,      0};
    vecs[3] = '{3'd4, 32'h10,       1'b1, 0, 0, 0, 0, 0,  3, 32'h110,      0};
    vecs[4] = '{3'd4, 32'h40,       1'b0, 0, 0, 2, 0, 0,  5, 32'h114,      0};
    vecs[5] = '{3'd2, 32'h4,        1'b0, 0, 0, 0, 7, 0, 12, 32'h118,      8};
    vecs[6] = '{3'd3, 32'h8,        1'b0, 0, 0, 0, 0, 0,  4, 32'h11C,      1};
    vecs[7] = '{3'd5, 32'hFFFFFEE4, 1'b0, 0, 0, 0, 0, 1,  5, 32'h0,        0};
    vecs[8] = '{3'd5, 32'hFFFFFFFC, 1'b0, 0, 0, 0, 0, 0,  4, 32'hFFFFFFFC, 0};
    vecs[9] = '{3'd0, 32'h0,        1'b0, 0, 0, 0, 0, 0,  4, 32'h0,        0};

    // ---- reset state ----
    reset = 1'b1; run = 1'b0; clear_acks();
    instr_type = 3'd0; imm = 32'h0; alu_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_pc", pc, 32'h0);
    check("rst_outs", 32'({instr_req, rf_req, alu_req, mem_req, wb_req, retire, busy, trap}), 32'h0);
    check("rst_cause_sel", 32'({trap_cause, wb_sel}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle_no_run", 32'(state_dbg), 32'(ST_IDLE));
    run = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      do_instr(vecs[i].t, vecs[i].im, vecs[i].tk, vecs[i].df, vecs[i].dr, vecs[i].da,
               vecs[i].dm, vecs[i].dw, 1'b0, 1'b0, lat, mcyc);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_mem_cycles", i), 32'(mcyc), 32'(vecs[i].exp_mem));
      check($sformatf("vec%0d_next_fetch", i), 32'(instr_req), 32'd1);
    end
    model_pc = 32'h0;

    // ---- randomized instructions with spurious acks ----
    repeat (40) begin
      t  = 3'($urandom_range(0, 5));
      im = $urandom;
      tk = 1'($urandom_range(0, 1));
      df = $urandom_range(0, 3); dr = $urandom_range(0, 3); da = $urandom_range(0, 3);
      dm = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      exp_lat = model_latency(t, df, dr, da, dm, dw);
      exp_q.push_back(model_next_pc(model_pc, t, im, tk));
      do_instr(t, im, tk, df, dr, da, dm, dw, 1'b1, 1'b0, lat, mcyc);
      exp_pc = exp_q.pop_front();
      check("rand_latency", 32'(lat), 32'(exp_lat));
      check("rand_pc", pc, exp_pc);
      model_pc = exp_pc;
    end

    // ---- run dropped mid-instruction: completes, then IDLE ----
    exp_pc = model_next_pc(model_pc, 3'd1, 32'h0, 1'b0);
    do_instr(3'd1, 32'h0, 1'b0, 0, 1, 1, 0, 1, 1'b0, 1'b1, lat, mcyc);
    check("drop_run_pc", pc, exp_pc);
    check("drop_run_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("drop_run_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("drop_run_stays_idle", 32'(instr_req), 32'd0);
    run = 1'b1;

    // ---- illegal type -> TRAP, recovery to IDLE with RESET_PC ----
    @(negedge clk);
    instr_type = 3'd7; instr_ack = 1'b1;
    @(posedge clk);
    #1;
    clear_acks();
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_reqs", 32'({instr_req, rf_req, alu_req, mem_req, wb_req}), 32'h0);
    @(negedge clk);
    rf_ack = 1'b1; alu_ack = 1'b1; wb_ack = 1'b1;   // ignored while parked
    #1;
    check("trap_held_run_high", 32'(state_dbg), 32'(ST_TRAP));
    run = 1'b0;
    @(negedge clk);
    clear_acks();
    #1;
    check("trap_held_run_low", 32'({trap, trap_cause}), 32'h5);
    run = 1'b1;
    @(posedge clk);
    #1;
    check("recover_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("recover_pc", pc, 32'h0);
    check("recover_trap", 32'(trap), 32'd0);

    // ---- reset during MEM aborts with no retire ----
    do_instr(3'd5, 32'h40, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, lat, mcyc);
    check("pre_reset_pc", pc, 32'h40);
    for (int k = 0; k < 20 && mem_req !== 1'b1; k++) begin
      @(negedge clk);
      instr_type = 3'd2; imm = 32'h0;
      instr_ack = instr_req; rf_ack = rf_req; alu_ack = alu_req; mem_ack = 1'b0;
      #1;
    end
    check("reach_mem", 32'(mem_req), 32'd1);
    @(negedge clk);
    clear_acks();
    mem_ack = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_reset_retire", 32'(retire), 32'd0);
    check("mid_reset_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_reset_pc", pc, 32'h0);
    check("mid_reset_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0; run = 1'b0; clear_acks();
    @(negedge clk);
    #1;
    check("post_reset_idle", 32'(state_dbg), 32'(ST_IDLE));

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
